// File: rtl/cpu_host_pkg.sv
// Shared types and default widths for the host-side program loader.
// The widths match the accumulator CPU datapath.
package cpu_host_pkg;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_IDLE,
        ST_START_HI,
        ST_START_LO,
        ST_WAIT_ACK,
        ST_RUN
    } host_state_e;

    // The states in which the watchdog runs.
    function automatic logic is_wait_state(input host_state_e s);
        return (s == ST_WAIT_IDLE) || (s == ST_WAIT_ACK) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/host_watchdog.sv
// Cycle watchdog for the loader's wait states. expired is raised on the cycle
// whose increment brings the count to all-ones.
module host_watchdog #(
    parameter int TMO_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // One below all-ones, so the registered timeout pulse lines up with a full count.
    localparam logic [TMO_W-1:0] EXPIRE_AT = ~TMO_W'(1);

    logic [TMO_W-1:0] cnt_q;

    // NOTE: state registers use non-blocking assignments and an asynchronous reset branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + TMO_W'(1);
        end
    end

    assign expired = en && (cnt_q == EXPIRE_AT);

endmodule

// File: rtl/cpu_host_loader.sv
// Loads a byte stream into CPU program memory, then runs the CPU through its
// start/done handshake and reports completion or watchdog timeout.
module cpu_host_loader
    import cpu_host_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                TMO_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_go,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_start,
    input  logic              cpu_done,
    output logic              busy,
    output logic              finished,
    output logic              timeout
);

    host_state_e       state_q;
    logic [ADDR_W-1:0] addr_cnt_q;
    logic [ADDR_W-1:0] remaining_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              cpu_start_q;
    logic              busy_q;
    logic              finished_q;
    logic              timeout_q;

    logic wd_clr;
    logic wd_en;
    logic wd_expired;

    // Clearing outside the wait states, and on the WAIT_ACK->RUN step, restarts the count on each entry.
    assign wd_en  = is_wait_state(state_q);
    assign wd_clr = !wd_en || ((state_q == ST_WAIT_ACK) && !cpu_done);

    host_watchdog #(
        .TMO_W (TMO_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_cnt_q  <= '0;
            remaining_q <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_start_q <= 1'b0;
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            mem_we_q    <= 1'b0;
            cpu_start_q <= 1'b0;
            finished_q  <= 1'b0;
            timeout_q   <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (load_go) begin
                        remaining_q <= load_len;
                        addr_cnt_q  <= BASE_ADDR;
                        busy_q      <= 1'b1;
                        state_q     <= (load_len != '0) ? ST_LOAD : ST_WAIT_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_cnt_q;
                        mem_wdata_q <= in_data;
                        addr_cnt_q  <= addr_cnt_q + ADDR_W'(1);
                        remaining_q <= remaining_q - ADDR_W'(1);
                        if (remaining_q == ADDR_W'(1)) begin
                            state_q <= ST_WAIT_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (cpu_done) begin
                        cpu_start_q <= 1'b1;
                        state_q     <= ST_START_HI;
                    end else if (wd_expired) begin
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_START_HI: state_q <= ST_START_LO;
                ST_START_LO: state_q <= ST_WAIT_ACK;
                ST_WAIT_ACK: begin
                    if (!cpu_done) begin
                        state_q <= ST_RUN;
                    end else if (wd_expired) begin
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // A done arriving on the expiry cycle takes priority over the timeout.
                    if (cpu_done) begin
                        finished_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else if (wd_expired) begin
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: in_ready is a pure decode of the state so it drops on the same edge as the last accepted byte.
    assign in_ready  = (state_q == ST_LOAD);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_start = cpu_start_q;
    assign busy      = busy_q;
    assign finished  = finished_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_cpu_host_loader.sv
// Scoreboard bench for cpu_host_loader: one instance at BASE_ADDR 0 and one at the
// top of memory, both with a 4-bit watchdog so the timeout is reachable quickly.
`timescale 1ns/1ps
module tb_cpu_host_loader;

    localparam int AW = 13;
    localparam int DW = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_go_a, load_go_b;
    logic [AW-1:0] load_len;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          cpu_done;

    logic          a_in_ready, a_mem_we, a_cpu_start, a_busy, a_finished, a_timeout;
    logic [AW-1:0] a_mem_addr;
    logic [DW-1:0] a_mem_wdata;
    logic          b_in_ready, b_mem_we, b_cpu_start, b_busy, b_finished, b_timeout;
    logic [AW-1:0] b_mem_addr;
    logic [DW-1:0] b_mem_wdata;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  wr_cnt[2], start_cnt[2], fin_cnt[2], to_cnt[2];
    int  snap_wr, snap_start, snap_fin, snap_to;

    always #5 clk = ~clk;

    cpu_host_loader #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(13'd0), .TMO_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .load_go(load_go_a), .load_len(load_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .cpu_start(a_cpu_start), .cpu_done(cpu_done), .busy(a_busy),
        .finished(a_finished), .timeout(a_timeout)
    );

    cpu_host_loader #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(13'd8191), .TMO_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .load_go(load_go_b), .load_len(load_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .cpu_start(b_cpu_start), .cpu_done(cpu_done), .busy(b_busy),
        .finished(b_finished), .timeout(b_timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected write for every mem_we and tallies the pulse outputs.
    task automatic watch(input int id, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic pend, input logic start,
                         input logic fin, input logic to);
        wr_t e;
        if (we) begin
            wr_cnt[id]++;
            check($sformatf("wr_latency_%0d", id), pend, 1);
            if (exp_q.size() == 0) begin
                check($sformatf("unexpected_write_%0d", id), {addr, data}, 0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("wr_addr_%0d", id), addr, e.addr);
                check($sformatf("wr_data_%0d", id), data, e.data);
            end
        end else if (pend) begin
            check($sformatf("missing_write_%0d", id), we, 1);
        end
        if (start) start_cnt[id]++;
        if (fin)   fin_cnt[id]++;
        if (to)    to_cnt[id]++;
        if (fin || to) check($sformatf("fin_to_exclusive_%0d", id), fin & to, 0);
    endtask

    initial begin
        logic pend_a = 1'b0;
        logic pend_b = 1'b0;
        forever begin
            @(negedge clk);
            watch(0, a_mem_we, a_mem_addr, a_mem_wdata, pend_a, a_cpu_start, a_finished, a_timeout);
            watch(1, b_mem_we, b_mem_addr, b_mem_wdata, pend_b, b_cpu_start, b_finished, b_timeout);
            pend_a = in_valid && a_in_ready && !rst;
            pend_b = in_valid && b_in_ready && !rst;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [AW-1:0] len, input bit to_b);
        load_len = len;
        if (to_b) load_go_b = 1'b1;
        else      load_go_a = 1'b1;
        tick();
        load_go_a = 1'b0;
        load_go_b = 1'b0;
    endtask

    task automatic send_byte(input logic [DW-1:0] d, input bit to_b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!(to_b ? b_in_ready : a_in_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("byte_accepted", (n < 40), 1);
        tick();
        in_valid = 1'b0;
    endtask

    // CPU stand-in: sees the start pulse, stays busy for a while, returns to done.
    task automatic cpu_run(input int busy_cycles, input bit to_b);
        int n = 0;
        @(negedge clk);
        while (!(to_b ? b_cpu_start : a_cpu_start) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", (n < 40), 1);
        cpu_done = 1'b0;
        repeat (busy_cycles) @(negedge clk);
        cpu_done = 1'b1;
        n = 0;
        while ((to_b ? b_busy : a_busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("busy_drop", (to_b ? b_busy : a_busy), 0);
        tick();
    endtask

    task automatic snap(input int id);
        snap_wr    = wr_cnt[id];
        snap_start = start_cnt[id];
        snap_fin   = fin_cnt[id];
        snap_to    = to_cnt[id];
    endtask

    task automatic deltas(input string tag, input int id, input int wr, input int st,
                          input int fin, input int to);
        check({tag, "_writes"},   wr_cnt[id] - snap_wr, wr);
        check({tag, "_start"},    start_cnt[id] - snap_start, st);
        check({tag, "_finished"}, fin_cnt[id] - snap_fin, fin);
        check({tag, "_timeout"},  to_cnt[id] - snap_to, to);
    endtask

    function automatic logic [31:0] outs_a();
        return {5'd0, a_in_ready, a_mem_we, a_mem_addr, a_mem_wdata,
                a_cpu_start, a_busy, a_finished, a_timeout};
    endfunction

    function automatic logic [31:0] outs_b();
        return {5'd0, b_in_ready, b_mem_we, b_mem_addr, b_mem_wdata,
                b_cpu_start, b_busy, b_finished, b_timeout};
    endfunction

    initial begin
        int n;
        rst = 1'b1; load_go_a = 1'b0; load_go_b = 1'b0; load_len = '0;
        in_valid = 1'b0; in_data = '0; cpu_done = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_cnt[i] = 0; start_cnt[i] = 0; fin_cnt[i] = 0; to_cnt[i] = 0;
        end

        repeat (2) @(negedge clk);
        check("reset_outs_a", outs_a(), 0);
        check("reset_outs_b", outs_b(), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // 1: three bytes back-to-back.
        exp_q.push_back('{13'd0, 8'hA1});
        exp_q.push_back('{13'd1, 8'hB2});
        exp_q.push_back('{13'd2, 8'hC3});
        snap(0);
        go(3, 0);
        check("t1_busy", a_busy, 1);
        send_byte(8'hA1, 0);
        send_byte(8'hB2, 0);
        send_byte(8'hC3, 0);
        @(negedge clk);
        check("t1_ready_low", a_in_ready, 0);
        cpu_run(10, 0);
        deltas("t1", 0, 3, 1, 1, 0);

        // 2: same load with a one-cycle gap between bytes.
        exp_q.push_back('{13'd0, 8'hA1});
        exp_q.push_back('{13'd1, 8'hB2});
        exp_q.push_back('{13'd2, 8'hC3});
        snap(0);
        go(3, 0);
        send_byte(8'hA1, 0); tick();
        send_byte(8'hB2, 0); tick();
        send_byte(8'hC3, 0); tick();
        cpu_run(5, 0);
        deltas("t2", 0, 3, 1, 1, 0);

        // 3: zero-length load goes straight to the handshake.
        snap(0);
        go(0, 0);
        check("t3_busy", a_busy, 1);
        cpu_run(10, 0);
        deltas("t3", 0, 0, 1, 1, 0);

        // 4: CPU never returns to done; 3 cycles START_HI->RUN plus 15 in RUN.
        snap(0);
        go(0, 0);
        n = 0;
        @(negedge clk);
        while (!a_cpu_start && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t4_start_seen", (n < 40), 1);
        cpu_done = 1'b0;
        n = 0;
        while (!a_timeout && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("t4_timeout_latency", n, 18);
        tick();
        check("t4_busy", a_busy, 0);
        deltas("t4", 0, 0, 1, 0, 1);
        cpu_done = 1'b1;
        tick();

        // 5: reset after the first of four bytes, then a clean two-byte session.
        exp_q.push_back('{13'd0, 8'h5A});
        snap(0);
        go(4, 0);
        send_byte(8'h5A, 0);
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'h66;
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_reset_outs", outs_a(), 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        deltas("t5a", 0, 1, 0, 0, 0);
        exp_q.push_back('{13'd0, 8'h11});
        exp_q.push_back('{13'd1, 8'h22});
        snap(0);
        go(2, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        cpu_run(4, 0);
        deltas("t5b", 0, 2, 1, 1, 0);

        // 6: address wrap from the top of memory.
        exp_q.push_back('{13'd8191, 8'hD1});
        exp_q.push_back('{13'd0,    8'hD2});
        snap(1);
        go(2, 1);
        send_byte(8'hD1, 1);
        send_byte(8'hD2, 1);
        cpu_run(3, 1);
        deltas("t6", 1, 2, 1, 1, 0);

        repeat (3) tick();
        check("exp_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
